uart_rx: RTL and testbench

- Serial receive front-end feeding the peripheral block's UART receive-data register (read at 0x4000001C).
- Samples the asynchronous PC_Uart_rxd line at 16x baud using majority voting, and assembles 8N1 frames, LSB first.
- Holds each byte until the peripheral acknowledges it.
- Flags frame and overrun errors, and pulses an interrupt request on every completed byte.

---
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling with a 2-of-3 vote
// around mid-bit, and a held byte with ready/irq plus sticky frame/overrun flags.
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 4800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_irq,
  output logic       frame_err,
  output logic       overrun
);

  localparam int OVS   = 16;
  localparam int DIV   = CLK_FREQ / (BAUD * OVS);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       s_q, s_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       smp_q, smp_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rxs_q, rxs_d;
  logic             armed_q, armed_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             irq_q, irq_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic tick, vote, decide, bit_end, byte_ok, ferr_set;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    s_d       = s_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    smp_d     = smp_q;
    armed_d   = armed_q;
    data_d    = data_q;
    rx_meta_d = uart_rxd;
    rxs_d     = rx_meta_q;
    byte_ok   = 1'b0;
    ferr_set  = 1'b0;

    tick    = (div_q == DIV_MAX);
    vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
    decide  = tick && (s_q == 4'd9);
    bit_end = tick && (s_q == 4'd15);

    div_d = tick ? '0 : div_q + DIV_W'(1);
    if (tick) begin
      s_d = s_q + 4'd1;
      if (s_q == 4'd7) smp_d[0] = rxs_q;
      if (s_q == 4'd8) smp_d[1] = rxs_q;
    end
    if (rxs_q) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        div_d = '0;
        s_d   = 4'd0;
        if (!rxs_q && armed_q) state_d = START;
      end
      START: begin
        if (decide && vote) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (decide) shift_d[idx_q] = vote;
        if (bit_end) begin
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (decide) begin
          data_d  = shift_q;
          state_d = IDLE;
          if (vote) begin
            byte_ok = 1'b1;
          end else begin
            ferr_set = 1'b1;
            // a stuck-low line must go high again before the next start counts
            armed_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = byte_ok ? 1'b1 : (rx_ack ? 1'b0 : ready_q);
    irq_d   = byte_ok;
    ferr_d  = (ferr_q & ~err_clr) | ferr_set;
    ovr_d   = (ovr_q & ~err_clr) | (byte_ok & ready_q & ~rx_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      s_q       <= 4'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      smp_q     <= 2'b11;
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      armed_q   <= 1'b1;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      irq_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      s_q       <= s_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      smp_q     <= smp_d;
      rx_meta_q <= rx_meta_d;
      rxs_q     <= rxs_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      irq_q     <= irq_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_ready  = ready_q;
  assign rx_irq    = irq_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: frames are driven at a scaled baud (DIV = 4,
// 64 clocks per bit); expected bytes and flag states come from a simple model.
module tb_uart_rx;
  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       reset, uart_rxd, rx_ack, err_clr;
  logic [7:0] rx_data;
  logic       rx_ready, rx_irq, frame_err, overrun;

  uart_rx #(.CLK_FREQ(50000000), .BAUD(781250)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .rx_ack(rx_ack),
    .err_clr(err_clr), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_irq(rx_irq), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_irq_cyc = -1;
  logic prev_irq = 1'b0;
  logic [7:0] exp_q[$];
  bit m_ready = 0, m_ovr = 0, m_ferr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every irq must match the oldest expected byte
  always begin
    @(posedge clk);
    #1;
    if (rx_irq) begin
      check("irq_single_clock", {31'd0, prev_irq}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_irq: got data %0h expected no byte", rx_data);
      end else begin
        check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      check("ready_with_irq", {31'd0, rx_ready}, 32'd1);
      last_irq_cyc = cyc;
    end
    prev_irq = rx_irq;
  end

  task automatic send_bit(input logic b);
    uart_rxd = b;
    repeat (BIT) @(negedge clk);
  endtask

  // ack_at_done pulses rx_ack on the clock the stop bit is decided
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit ack_at_done);
    if (stop) exp_q.push_back(d);
    if (ack_at_done) begin
      fork
        begin
          repeat (618) @(negedge clk);
          rx_ack = 1'b1;
          @(negedge clk);
          rx_ack = 1'b0;
        end
      join_none
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    uart_rxd = 1'b1;
    if (stop) begin
      if (m_ready && !ack_at_done) m_ovr = 1;
      m_ready = 1;
    end else begin
      m_ferr = 1;
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_ready = 0;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ferr = 0;
    m_ovr = 0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ready"}, {31'd0, rx_ready}, {31'd0, m_ready});
    check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
    check({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, m_ferr});
  endtask

  initial begin
    int c0;
    logic [7:0] d;
    logic stop;

    uart_rxd = 1'b1; reset = 1'b1; rx_ack = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_data", {24'd0, rx_data}, 32'h0);
    check("reset_irq", {31'd0, rx_irq}, 32'd0);
    check_flags("reset");
    repeat (2000) @(negedge clk);
    check_flags("idle");

    c0 = cyc;
    send_frame(8'h4D, 1'b1, 1'b0);
    check_flags("f4d");
    check("f4d_latency", {31'd0, (last_irq_cyc - c0 >= 600) && (last_irq_cyc - c0 <= 640)}, 32'd1);
    ack_pulse();
    check_flags("f4d_ack");

    uart_rxd = 1'b0;
    repeat (6) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check_flags("glitch");
    send_frame(8'hA5, 1'b1, 1'b0);
    check_flags("fa5");
    ack_pulse();

    send_frame(8'h55, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    check_flags("ferr");
    check("ferr_data", {24'd0, rx_data}, 32'h55);
    clr_pulse();
    check_flags("ferr_clr");

    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    check("ovr_data", {24'd0, rx_data}, 32'h34);
    check_flags("ovr");
    clr_pulse();
    ack_pulse();
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1);
    check_flags("ack_same_clk");
    ack_pulse();

    uart_rxd = 1'b0;
    repeat (30 * BIT) @(negedge clk);
    m_ferr = 1;
    check_flags("stuck_low");
    clr_pulse();
    repeat (20 * BIT) @(negedge clk);
    check_flags("stuck_low_once");
    uart_rxd = 1'b1;
    repeat (16) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b0);
    check_flags("after_break");

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    reset = 1'b0;
    exp_q.delete();
    m_ready = 0; m_ovr = 0; m_ferr = 0;
    check("midreset_data", {24'd0, rx_data}, 32'h0);
    check_flags("midreset");
    repeat (20 * BIT) @(negedge clk);
    check_flags("midreset_idle");
    send_frame(8'hC3, 1'b1, 1'b0);
    check("fc3_data", {24'd0, rx_data}, 32'hC3);
    check_flags("fc3");
    ack_pulse();

    for (int n = 0; n < 14; n++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, stop, 1'b0);
      repeat (8 + $urandom_range(0, 40)) @(negedge clk);
      check("rand_data", {24'd0, rx_data}, {24'd0, d});
      check_flags("rand");
      if ($urandom_range(0, 1) == 1) ack_pulse();
      if ($urandom_range(0, 3) == 0) clr_pulse();
    end

    repeat (4) @(negedge clk);
    check("pending_bytes", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
